// File: rtl/param_counter.sv
// Parametrised 161-style synchronous counter: up/down, programmable terminal TOP,
// wrap or saturate, registered terminal pulse TC, sticky OVF, ENP/ENT/RCO cascade.
module param_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             SCLR_n,
  input  logic             LOAD_n,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] TOP,
  input  logic             UP,
  input  logic             ENP,
  input  logic             ENT,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC,
  output logic             OVF
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_term_s;

  // Up-counting treats anything at or above TOP as terminal so a loaded D>TOP never climbs further.
  always_comb begin
    if (UP) begin
      at_term_s = (q_q >= TOP);
    end else begin
      at_term_s = (q_q == {WIDTH{1'b0}});
    end
  end

  // Next-state: clear beats load, load beats count, otherwise hold.
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (!SCLR_n) begin
      q_d   = {WIDTH{1'b0}};
      ovf_d = 1'b0;
    end else if (!LOAD_n) begin
      q_d = D;
    end else if (ENP && ENT) begin
      if (at_term_s) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (SATURATE) begin
          q_d = q_q;
        end else if (UP) begin
          q_d = {WIDTH{1'b0}};
        end else begin
          q_d = TOP;
        end
      end else if (UP) begin
        q_d = q_q + WIDTH'(1);
      end else begin
        q_d = q_q - WIDTH'(1);
      end
    end else begin
      q_d = q_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      q_q   <= {WIDTH{1'b0}};
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  // RCO is deliberately combinational and ignores ENP/LOAD_n/SCLR_n so stages chain like the 161.
  assign RCO = ENT & at_term_s;
  assign Q   = q_q;
  assign TC  = tc_q;
  assign OVF = ovf_q;

endmodule
